div4_stream_ctrl: RTL and testbench

DIV4_STREAM_CTRL -- requirements
Module: div4_stream_ctrl

---
 rtl/div4_pkg.sv | 18 +
 rtl/div4_result_fifo.sv | 46 ++++
 rtl/div4_stream_ctrl.sv | 85 ++++++++
 tb/tb_div4_stream_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div4_pkg.sv
// Shared widths, result-entry layout and the divide-by-zero quotient marker
// for the 4-by-2 divider stream controller.
package div4_pkg;

    localparam int A_W = 4;
    localparam int B_W = 2;
    localparam int Q_W = 4;
    localparam int R_W = 4;

    localparam logic [Q_W-1:0] DZ_Q = 4'hF;

    typedef struct packed {
        logic [Q_W-1:0] q;
        logic [R_W-1:0] r;
        logic           dz;
    } entry_t;

endpackage

// File: rtl/div4_result_fifo.sv
// Result FIFO: DEPTH entries, write-to-head visible one edge after push.
// No internal protection; the caller never pushes when full nor pops when empty.
module div4_result_fifo
    import div4_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  entry_t                   push_dat,
    input  logic                     pop,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/div4_stream_ctrl.sv
// Operand register feeding an external 4/2 divider, results queued in a FIFO.
// Two edges accept-to-out_valid; in_ready reserves a FIFO slot for the operand stage.
module div4_stream_ctrl
    import div4_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [A_W-1:0]  in_a,
    input  logic [B_W-1:0]  in_b,
    output logic [A_W-1:0]  div_a,
    output logic [B_W-1:0]  div_b,
    input  logic [Q_W-1:0]  div_q,
    input  logic [R_W-1:0]  div_r,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [Q_W-1:0]  out_q,
    output logic [R_W-1:0]  out_r,
    output logic            out_dz,
    output logic [7:0]      dz_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

    logic           op_valid;
    logic [CW-1:0]  fifo_count;
    logic [CW:0]    occupancy;
    logic           accept;
    logic           pop;
    logic           wr_dz;
    entry_t         wr_ent;
    entry_t         head;

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign accept    = in_valid && in_ready;

    // A pop on this edge frees a slot, so it is subtracted before the compare.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, op_valid} - {{CW{1'b0}}, pop};
    assign in_ready  = (occupancy < DEPTH_L);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            div_a    <= '0;
            div_b    <= '0;
            dz_count <= '0;
        end else begin
            op_valid <= accept;
            if (accept) begin
                div_a <= in_a;
                div_b <= in_b;
                if ((in_b == '0) && (dz_count != 8'hFF)) dz_count <= dz_count + 8'd1;
            end
        end
    end

    // Divider outputs are meaningless for a zero divisor; substitute the marker.
    assign wr_dz    = (div_b == '0);
    assign wr_ent.q  = wr_dz ? DZ_Q  : div_q;
    assign wr_ent.r  = wr_dz ? div_a : div_r;
    assign wr_ent.dz = wr_dz;

    div4_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (op_valid),
        .push_dat (wr_ent),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count)
    );

    // Stale memory behind an empty FIFO is masked so outputs read zero.
    assign out_q  = out_valid ? head.q  : '0;
    assign out_r  = out_valid ? head.r  : '0;
    assign out_dz = out_valid ? head.dz : 1'b0;

endmodule

// File: tb/tb_div4_stream_ctrl.sv
// Randomized bench for div4_stream_ctrl with a queue-based reference model
// and a behavioural divider attached to div_a/div_b.
module tb_div4_stream_ctrl;
    import div4_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [1:0] in_b;
    logic [3:0] div_a;
    logic [1:0] div_b;
    logic [3:0] div_q;
    logic [3:0] div_r;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_q;
    logic [3:0] out_r;
    logic       out_dz;
    logic [7:0] dz_count;

    int total = 0;
    int bad   = 0;
    int exp_dz = 0;
    entry_t mq[$];

    always #5 clk = ~clk;

    // Divider returns junk for a zero divisor so the substitution is visible.
    assign div_q = (div_b != 2'd0) ? div_a / {2'b00, div_b} : 4'h5;
    assign div_r = (div_b != 2'd0) ? div_a % {2'b00, div_b} : 4'hA;

    div4_stream_ctrl #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_q     (div_q),
        .div_r     (div_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_r     (out_r),
        .out_dz    (out_dz),
        .dz_count  (dz_count)
    );

    function automatic entry_t ref_div(input int a, input int b);
        entry_t e;
        if (b == 0) begin
            e.q = 4'hF; e.r = 4'(a); e.dz = 1'b1;
        end else begin
            e.q = 4'(a / b); e.r = 4'(a % b); e.dz = 1'b0;
        end
        return e;
    endfunction

    // Drive one cycle's inputs, report which handshakes the next edge performs.
    task automatic step(input logic iv, input logic [3:0] a, input logic [1:0] b,
                        input logic ordy, output logic acc, output logic pop,
                        output entry_t obs);
        @(negedge clk);
        in_valid = iv; in_a = a; in_b = b; out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        pop = out_valid && out_ready;
        obs.q = out_q; obs.r = out_r; obs.dz = out_dz;
        if (acc) begin
            mq.push_back(ref_div(int'(a), int'(b)));
            if (b == 2'd0 && exp_dz < 255) exp_dz++;
        end
    endtask

    task automatic drain(input string name);
        logic acc, pop;
        entry_t obs, exp;
        for (int i = 0; i < 40 && mq.size() > 0; i++) begin
            step(1'b0, 4'd0, 2'd0, 1'b1, acc, pop, obs);
            if (pop) begin
                exp = mq.pop_front();
                total++;
                if (obs !== exp)
                    $display("FAIL %s_order: got %h want %h", name, obs, exp);
                if (obs !== exp) bad++;
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        total++;
        if (mq.size() != 0 || out_valid !== 1'b0) begin
            $display("FAIL %s_empty: left=%0d out_valid=%b want 0/0", name, mq.size(), out_valid);
            bad++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if ({out_valid, in_ready, out_q, out_r, out_dz, dz_count, div_a, div_b} !==
            {1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 4'h0, 2'h0}) begin
            $display("FAIL reset_state: ov=%b ir=%b q=%h r=%h dz=%b cnt=%0d a=%h b=%h",
                     out_valid, in_ready, out_q, out_r, out_dz, dz_count, div_a, div_b);
            bad++;
        end
    endtask

    task automatic test_basic;
        logic acc, pop;
        entry_t obs, exp;
        step(1'b1, 4'd13, 2'd3, 1'b0, acc, pop, obs);
        total++;
        if (acc !== 1'b1) begin $display("FAIL basic_accept: got %b want 1", acc); bad++; end
        step(1'b0, 4'd0, 2'd0, 1'b0, acc, pop, obs);
        total++;
        if (out_valid !== 1'b0) begin $display("FAIL basic_early: out_valid=%b want 0", out_valid); bad++; end
        step(1'b1, 4'd9, 2'd0, 1'b1, acc, pop, obs);
        total++;
        if (out_valid !== 1'b1 || obs !== {4'd4, 4'd1, 1'b0}) begin
            $display("FAIL basic_13_3: ov=%b got %h want %h", out_valid, obs, {4'd4, 4'd1, 1'b0});
            bad++;
        end
        if (pop) void'(mq.pop_front());
        step(1'b0, 4'd0, 2'd0, 1'b0, acc, pop, obs);
        step(1'b0, 4'd0, 2'd0, 1'b0, acc, pop, obs);
        exp = {4'hF, 4'd9, 1'b1};
        total++;
        if (obs !== exp || dz_count !== 8'd1) begin
            $display("FAIL basic_9_0: got %h cnt=%0d want %h cnt=1", obs, dz_count, exp);
            bad++;
        end
        drain("basic");
    endtask

    task automatic fill(output int n_acc);
        logic acc, pop;
        entry_t obs;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'b0, acc, pop, obs);
            if (acc) n_acc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    task automatic test_fill;
        int n;
        fill(n);
        total++;
        if (n != 4 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            $display("FAIL fill_limit: accepted=%0d ir=%b ov=%b want 4/0/1", n, in_ready, out_valid);
            bad++;
        end
        drain("fill");
    endtask

    task automatic test_back_to_back;
        int n, misses;
        logic acc, pop;
        entry_t obs, exp;
        misses = 0;
        fill(n);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'b1, acc, pop, obs);
            if (!(acc && pop)) misses++;
            if (pop) begin
                exp = mq.pop_front();
                total++;
                if (obs !== exp) begin $display("FAIL b2b_data: got %h want %h", obs, exp); bad++; end
            end
        end
        total++;
        if (misses != 0) begin $display("FAIL b2b_rate: missed=%0d want 0", misses); bad++; end
        drain("b2b");
    endtask

    task automatic test_random;
        logic acc, pop, hold;
        entry_t obs, exp, prev;
        int unstable;
        hold = 1'b0; unstable = 0; prev = '0;
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7), acc, pop, obs);
            if (hold && obs !== prev) unstable++;
            hold = out_valid && !out_ready;
            prev = obs;
            if (pop) begin
                exp = mq.pop_front();
                total++;
                if (obs !== exp) begin $display("FAIL rand_data: got %h want %h", obs, exp); bad++; end
            end
        end
        total++;
        if (unstable != 0) begin $display("FAIL rand_stable: changes=%0d want 0", unstable); bad++; end
        drain("rand");
        total++;
        if (dz_count !== 8'(exp_dz)) begin $display("FAIL rand_dzcnt: got %0d want %0d", dz_count, exp_dz); bad++; end
    endtask

    task automatic test_reset_flush;
        logic acc, pop;
        entry_t obs;
        int n, seen;
        n = 0; seen = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'($urandom_range(0, 15)), (i == 0) ? 2'd0 : 2'($urandom_range(0, 3)),
                 1'b0, acc, pop, obs);
            if (acc) n++;
        end
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        mq.delete();
        exp_dz = 0;
        total++;
        if (n != 4 || out_valid !== 1'b0 || dz_count !== 8'd0 || in_ready !== 1'b1) begin
            $display("FAIL flush_state: acc=%0d ov=%b cnt=%0d ir=%b want 4/0/0/1",
                     n, out_valid, dz_count, in_ready);
            bad++;
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'd0, 2'd0, 1'b1, acc, pop, obs);
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) begin $display("FAIL flush_stale: valid_cycles=%0d want 0", seen); bad++; end
    endtask

    task automatic test_dz_saturate;
        logic acc, pop;
        entry_t obs, exp;
        int decreases;
        logic [7:0] prev_cnt;
        decreases = 0; prev_cnt = dz_count;
        for (int i = 0; i < 310; i++) begin
            step(1'b1, 4'($urandom_range(0, 15)), 2'd0, 1'b1, acc, pop, obs);
            if (dz_count < prev_cnt) decreases++;
            prev_cnt = dz_count;
            if (pop) begin
                exp = mq.pop_front();
                total++;
                if (obs !== exp) begin $display("FAIL sat_data: got %h want %h", obs, exp); bad++; end
            end
        end
        drain("sat");
        total++;
        if (exp_dz != 255 || dz_count !== 8'hFF || decreases != 0) begin
            $display("FAIL sat_count: got %0d model %0d drops=%0d want 255", dz_count, exp_dz, decreases);
            bad++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_back_to_back();
        test_random();
        test_reset_flush();
        test_dz_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
